// File: rtl/division_sequencer.sv
// division_sequencer: sequences the calculator divide operation.
// Captures dividend and divisor from successive op_div pulses, then on
// op_quot/op_rem runs a WIDTH-cycle unsigned restoring division and presents
// the selected quotient or remainder. All outputs are registered.
//
// Ports:
//   clk_27mhz    - system clock, rising edge
//   reset        - synchronous active-high reset
//   op_div       - pulse: capture entry_value as next operand
//   op_quot      - pulse: compute/show quotient
//   op_rem       - pulse: compute/show remainder
//   op_clear     - pulse: abort and clear everything
//   entry_value  - operand currently keyed in (unsigned)
//   result       - selected quotient or remainder
//   result_valid - result holds a finished value
//   busy         - division iterations in progress
//   div_by_zero  - last computed division had divisor 0
//   stage        - 0 awaiting dividend, 1 awaiting divisor, 2 both captured
module division_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_27mhz,
  input  logic             reset,
  input  logic             op_div,
  input  logic             op_quot,
  input  logic             op_rem,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] entry_value,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             div_by_zero,
  output logic [1:0]       stage
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = WIDTH + 1;

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_READY,
    S_DIVIDE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [PW-1:0]    prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_rem_q, sel_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;
  logic [1:0]       stage_q, stage_d;

  // One restoring-division step. quot_q doubles as the dividend shift
  // register: its MSB feeds the partial remainder, quotient bits enter at LSB.
  logic [PW-1:0]    shifted;
  logic [PW-1:0]    trial;
  logic             fits;
  logic [PW-1:0]    prem_next;
  logic [WIDTH-1:0] quot_next;

  always_comb begin
    shifted   = PW'({prem_q, quot_q[WIDTH-1]});
    trial     = shifted - {1'b0, divisor_q};
    fits      = (shifted >= {1'b0, divisor_q});
    prem_next = fits ? trial : shifted;
    quot_next = WIDTH'({quot_q, fits});
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    prem_d     = prem_q;
    cnt_d      = cnt_q;
    sel_rem_d  = sel_rem_q;
    result_d   = result_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    dbz_d      = dbz_q;
    stage_d    = stage_q;

    unique case (state_q)
      S_WAIT_A: begin
        if (op_div) begin
          dividend_d = entry_value;
          state_d    = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (op_div) begin
          divisor_d = entry_value;
          state_d   = S_READY;
        end
      end
      S_READY: begin
        // op_div outranks the compute pulses but is itself ignored here
        if (!op_div && (op_quot || op_rem)) begin
          sel_rem_d = !op_quot;
          quot_d    = dividend_q;
          prem_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        quot_d = quot_next;
        prem_d = prem_next;
        cnt_d  = cnt_q + CW'(1);
        // Final step: publish straight from the step outputs
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          dbz_d    = (divisor_q == '0);
          result_d = sel_rem_q ? prem_next[WIDTH-1:0] : quot_next;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (op_div) begin
          dividend_d = entry_value;
          divisor_d  = '0;
          valid_d    = 1'b0;
          dbz_d      = 1'b0;
          state_d    = S_WAIT_B;
        end else if (op_quot) begin
          sel_rem_d = 1'b0;
          result_d  = quot_q;
        end else if (op_rem) begin
          sel_rem_d = 1'b1;
          result_d  = prem_q[WIDTH-1:0];
        end
      end
      default: state_d = S_WAIT_A;
    endcase

    if (op_clear) begin
      state_d    = S_WAIT_A;
      dividend_d = '0;
      divisor_d  = '0;
      quot_d     = '0;
      prem_d     = '0;
      cnt_d      = '0;
      sel_rem_d  = 1'b0;
      result_d   = '0;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      dbz_d      = 1'b0;
    end

    unique case (state_d)
      S_WAIT_A: stage_d = 2'd0;
      S_WAIT_B: stage_d = 2'd1;
      default:  stage_d = 2'd2;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      state_q    <= S_WAIT_A;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      prem_q     <= '0;
      cnt_q      <= '0;
      sel_rem_q  <= 1'b0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      dbz_q      <= 1'b0;
      stage_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      prem_q     <= prem_d;
      cnt_q      <= cnt_d;
      sel_rem_q  <= sel_rem_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      dbz_q      <= dbz_d;
      stage_q    <= stage_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;
  assign div_by_zero  = dbz_q;
  assign stage        = stage_q;

endmodule

// File: tb/tb_division_sequencer.sv
// Bench for division_sequencer: directed scenarios with literal expectations
// plus randomized pulses, all checked each cycle against a transaction-level
// model that computes results with plain / and %.
module tb_division_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         op_div = 1'b0, op_quot = 1'b0, op_rem = 1'b0, op_clear = 1'b0;
  logic [W-1:0] entry = '0;
  logic [W-1:0] result;
  logic         result_valid, busy, div_by_zero;
  logic [1:0]   stage;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  division_sequencer #(.WIDTH(W)) dut (
    .clk_27mhz   (clk),
    .reset       (reset),
    .op_div      (op_div),
    .op_quot     (op_quot),
    .op_rem      (op_rem),
    .op_clear    (op_clear),
    .entry_value (entry),
    .result      (result),
    .result_valid(result_valid),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .stage       (stage)
  );

  // Behavioural model: phase 0 want A, 1 want B, 2 ready, 3 dividing, 4 done
  int           m_phase = 0;
  int           m_left  = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0, m_result = '0;
  bit           m_selrem = 0, m_valid = 0, m_busy = 0, m_dbz = 0;

  function automatic logic [1:0] m_stage();
    if (m_phase == 0) return 2'd0;
    if (m_phase == 1) return 2'd1;
    return 2'd2;
  endfunction

  always @(posedge clk) begin
    if (reset || op_clear) begin
      m_phase = 0; m_left = 0;
      m_a = '0; m_b = '0; m_q = '0; m_r = '0; m_result = '0;
      m_selrem = 0; m_valid = 0; m_busy = 0; m_dbz = 0;
    end else begin
      case (m_phase)
        0: if (op_div) begin m_a = entry; m_phase = 1; end
        1: if (op_div) begin m_b = entry; m_phase = 2; end
        2: if (!op_div && (op_quot || op_rem)) begin
             m_selrem = !op_quot; m_phase = 3; m_left = W; m_busy = 1;
           end
        3: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            if (m_b == 0) begin m_q = '1; m_r = m_a; end
            else begin m_q = m_a / m_b; m_r = m_a % m_b; end
            m_dbz = (m_b == 0);
            m_busy = 0; m_valid = 1; m_phase = 4;
            m_result = m_selrem ? m_r : m_q;
          end
        end
        4: begin
          if (op_div) begin
            m_a = entry; m_b = '0; m_valid = 0; m_dbz = 0; m_phase = 1;
          end else if (op_quot) begin
            m_selrem = 0; m_result = m_q;
          end else if (op_rem) begin
            m_selrem = 1; m_result = m_r;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (result !== m_result || result_valid !== m_valid || busy !== m_busy ||
          div_by_zero !== m_dbz || stage !== m_stage()) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got res=%0d v=%b busy=%b dbz=%b stage=%0d, want res=%0d v=%b busy=%b dbz=%b stage=%0d",
                 $time, result, result_valid, busy, div_by_zero, stage,
                 m_result, m_valid, m_busy, m_dbz, m_stage());
      end
    end
  end

  task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    op_div = 0; op_quot = 0; op_rem = 0; op_clear = 0; reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_op(input bit d, input bit q, input bit r, input bit c, input logic [W-1:0] v);
    entry = v; op_div = d; op_quot = q; op_rem = r; op_clear = c;
    tick();
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sel_rem,
                         input logic [W-1:0] exp, input string name);
    do_op(0, 0, 0, 1, 0);
    do_op(1, 0, 0, 0, a);
    do_op(1, 0, 0, 0, b);
    do_op(0, !sel_rem, sel_rem, 0, 0);
    idle(W);
    lit(name, result, exp);
    lit({name, "_valid"}, 8'(result_valid), 8'd1);
  endtask

  initial begin
    reset = 1; tick();
    reset = 1; tick();
    chk_en = 1;
    lit("rst_stage", 8'(stage), 8'd0);
    lit("rst_result", result, 8'd0);
    lit("rst_valid", 8'(result_valid), 8'd0);
    lit("rst_busy", 8'(busy), 8'd0);
    lit("rst_dbz", 8'(div_by_zero), 8'd0);

    // op_quot in WAIT_A is ignored
    do_op(0, 1, 0, 0, 0);
    lit("quot_in_wait_a", 8'(stage), 8'd0);

    // 100 / 7
    do_op(1, 0, 0, 0, 100);
    lit("stage_after_a", 8'(stage), 8'd1);
    do_op(1, 0, 0, 0, 7);
    lit("stage_after_b", 8'(stage), 8'd2);
    do_op(0, 1, 0, 0, 0);
    lit("busy_first", 8'(busy), 8'd1);
    idle(W - 1);
    lit("busy_last", 8'(busy), 8'd1);
    lit("valid_during_busy", 8'(result_valid), 8'd0);
    idle(1);
    lit("busy_end", 8'(busy), 8'd0);
    lit("quot_100_7", result, 8'd14);
    lit("model_quot_100_7", m_result, 8'd14);
    do_op(0, 0, 1, 0, 0);
    lit("rem_100_7", result, 8'd2);
    lit("reselect_busy", 8'(busy), 8'd0);

    // New operation from DONE: 9 % 4
    do_op(1, 0, 0, 0, 9);
    lit("new_op_valid", 8'(result_valid), 8'd0);
    lit("new_op_stage", 8'(stage), 8'd1);
    do_op(1, 0, 0, 0, 4);
    do_op(0, 0, 1, 0, 0);
    idle(W);
    lit("rem_9_4", result, 8'd1);

    // Divide by zero
    do_op(0, 0, 0, 1, 0);
    do_op(1, 0, 0, 0, 55);
    do_op(1, 0, 0, 0, 0);
    do_op(0, 1, 0, 0, 0);
    idle(W);
    lit("quot_55_0", result, 8'd255);
    lit("dbz_55_0", 8'(div_by_zero), 8'd1);
    do_op(0, 0, 1, 0, 0);
    lit("rem_55_0", result, 8'd55);

    // Boundary operands
    run_div(255, 1, 0, 255, "quot_255_1");
    run_div(255, 1, 1, 0, "rem_255_1");
    run_div(3, 200, 0, 0, "quot_3_200");
    run_div(3, 200, 1, 3, "rem_3_200");
    run_div(200, 200, 0, 1, "quot_200_200");
    run_div(200, 200, 1, 0, "rem_200_200");

    // Abort on third busy cycle via op_clear, then via reset
    for (int k = 0; k < 2; k++) begin
      run_div(100, 7, 0, 14, "pre_abort");
      do_op(1, 0, 0, 0, 100);
      do_op(1, 0, 0, 0, 7);
      do_op(0, 1, 0, 0, 0);
      idle(2);
      if (k == 0) do_op(0, 0, 0, 1, 0);
      else begin reset = 1; tick(); end
      lit("abort_busy", 8'(busy), 8'd0);
      lit("abort_stage", 8'(stage), 8'd0);
      lit("abort_result", result, 8'd0);
      lit("abort_valid", 8'(result_valid), 8'd0);
    end

    // op_div during DIVIDE is ignored
    do_op(1, 0, 0, 0, 100);
    do_op(1, 0, 0, 0, 7);
    do_op(0, 1, 0, 0, 0);
    idle(1);
    do_op(1, 0, 0, 0, 50);
    idle(W - 2);
    lit("div_in_divide", result, 8'd14);

    // op_quot and op_rem together in READY: quotient wins
    do_op(0, 0, 0, 1, 0);
    do_op(1, 0, 0, 0, 100);
    do_op(1, 0, 0, 0, 7);
    do_op(0, 1, 1, 0, 0);
    idle(W);
    lit("quot_rem_together", result, 8'd14);

    // op_clear beats op_div
    do_op(1, 0, 0, 1, 33);
    lit("clear_vs_div_a", 8'(stage), 8'd0);
    do_op(1, 0, 0, 0, 20);
    do_op(1, 0, 0, 1, 5);
    lit("clear_vs_div_b", 8'(stage), 8'd0);

    // Randomized pulses checked by the model
    for (int i = 0; i < 3000; i++) begin
      entry    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      op_clear = ($urandom_range(0, 99) < 2);
      op_div   = ($urandom_range(0, 99) < 15);
      op_quot  = ($urandom_range(0, 99) < 20);
      op_rem   = ($urandom_range(0, 99) < 20);
      reset    = ($urandom_range(0, 199) == 0);
      tick();
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
